// File: rtl/sys_bus_arbiter.sv
// Multi-master request/grant/acknowledge arbiter in front of the single sys_bus port.
// Fixed-priority or round-robin selection, multi-cycle slaves via bus_ready, per-transaction timeout.
module sys_bus_arbiter #(
    parameter int unsigned N_MASTERS   = 2,
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned CTRL_W      = 3,
    parameter int unsigned RR_MODE     = 0,
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned GID_W       = $clog2(N_MASTERS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          m_req,
    input  logic [N_MASTERS*CTRL_W-1:0]   m_rd_ctrl,
    input  logic [N_MASTERS*CTRL_W-1:0]   m_wr_ctrl,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_din,
    output logic [DATA_W-1:0]             m_dout,
    output logic [N_MASTERS-1:0]          m_ack,
    output logic                          m_err,
    output logic [N_MASTERS-1:0]          m_stall,
    output logic [CTRL_W-1:0]             bus_rd_ctrl,
    output logic [CTRL_W-1:0]             bus_wr_ctrl,
    output logic [ADDR_W-1:0]             bus_addr,
    output logic [DATA_W-1:0]             bus_din,
    input  logic [DATA_W-1:0]             bus_dout,
    input  logic                          bus_ready,
    output logic                          busy,
    output logic [GID_W-1:0]              grant_id
);

    localparam int unsigned CNT_W   = $clog2(TIMEOUT_CYC + 1) > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit          TO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [GID_W-1:0]       r_gid;
    logic [GID_W-1:0]       r_ptr;
    logic [CNT_W-1:0]       r_cnt;
    logic [DATA_W-1:0]      r_dout;
    logic [N_MASTERS-1:0]   r_ack;
    logic                   r_err;
    logic                   r_busy;
    logic [CTRL_W-1:0]      r_bus_rd;
    logic [CTRL_W-1:0]      r_bus_wr;
    logic [ADDR_W-1:0]      r_bus_addr;
    logic [DATA_W-1:0]      r_bus_din;

    logic [N_MASTERS-1:0]   w_elig;
    logic                   w_any;
    logic [GID_W-1:0]       w_win;
    int unsigned            w_dist;
    int unsigned            w_best;
    logic [CTRL_W-1:0]      w_sel_rd;
    logic [CTRL_W-1:0]      w_sel_wr;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [DATA_W-1:0]      w_sel_din;
    logic [N_MASTERS-1:0]   w_gnt_oh;

    // A request only counts when it carries an actual read or write code.
    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_elig
        assign w_elig[gi] = m_req[gi] &
                            ((|m_rd_ctrl[gi*CTRL_W +: CTRL_W]) | (|m_wr_ctrl[gi*CTRL_W +: CTRL_W]));
    end

    // Winner = eligible master with the smallest distance from the priority origin.
    always_comb begin
        w_any  = 1'b0;
        w_win  = '0;
        w_dist = 0;
        w_best = N_MASTERS;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (RR_MODE != 0)
                w_dist = (unsigned'(i) + N_MASTERS - 1 - 32'(r_ptr)) % N_MASTERS;
            else
                w_dist = unsigned'(i);
            if (w_elig[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_win  = GID_W'(i);
                w_any  = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_rd   = '0;
        w_sel_wr   = '0;
        w_sel_addr = '0;
        w_sel_din  = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (w_win == GID_W'(i)) begin
                w_sel_rd   = m_rd_ctrl[i*CTRL_W +: CTRL_W];
                w_sel_wr   = m_wr_ctrl[i*CTRL_W +: CTRL_W];
                w_sel_addr = m_addr[i*ADDR_W +: ADDR_W];
                w_sel_din  = m_din[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_gnt_oh = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            w_gnt_oh[i] = (r_gid == GID_W'(i));
        end
    end

    // Arbitration FSM: IDLE picks a winner, BUSY holds the bus, DONE is the one-cycle ack slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_gid      <= '0;
            r_ptr      <= GID_W'(N_MASTERS - 1);
            r_cnt      <= '0;
            r_dout     <= '0;
            r_ack      <= '0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_bus_rd   <= '0;
            r_bus_wr   <= '0;
            r_bus_addr <= '0;
            r_bus_din  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack <= '0;
                    r_err <= 1'b0;
                    if (w_any) begin
                        r_bus_rd   <= w_sel_rd;
                        r_bus_wr   <= w_sel_wr;
                        r_bus_addr <= w_sel_addr;
                        r_bus_din  <= w_sel_din;
                        r_gid      <= w_win;
                        r_ptr      <= w_win;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (bus_ready) begin
                        r_dout     <= bus_dout;
                        r_ack      <= w_gnt_oh;
                        r_err      <= 1'b0;
                        r_bus_rd   <= '0;
                        r_bus_wr   <= '0;
                        r_bus_addr <= '0;
                        r_bus_din  <= '0;
                        r_busy     <= 1'b0;
                        r_state    <= S_DONE;
                    end else if (TO_EN && (r_cnt == TO_LAST)) begin
                        r_dout     <= '0;
                        r_ack      <= w_gnt_oh;
                        r_err      <= 1'b1;
                        r_bus_rd   <= '0;
                        r_bus_wr   <= '0;
                        r_bus_addr <= '0;
                        r_bus_din  <= '0;
                        r_busy     <= 1'b0;
                        r_state    <= S_DONE;
                    end else if (TO_EN) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_ack   <= '0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ack   <= '0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign m_dout      = r_dout;
    assign m_ack       = r_ack;
    assign m_err       = r_err;
    assign m_stall     = m_req & ~r_ack;
    assign bus_rd_ctrl = r_bus_rd;
    assign bus_wr_ctrl = r_bus_wr;
    assign bus_addr    = r_bus_addr;
    assign bus_din     = r_bus_din;
    assign busy        = r_busy;
    assign grant_id    = r_gid;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Scoreboard bench: a fixed-priority 2-master instance and a round-robin 3-master instance.
module tb_sys_bus_arbiter;

    typedef struct {
        logic [2:0]  ack;
        logic [63:0] dout;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_ack0 = 0;
    int   n_ack1 = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   tq[$];

    // Fixed-priority instance signals
    logic [1:0]   req0;
    logic [5:0]   rd0, wr0;
    logic [127:0] addr0, din0;
    logic [63:0]  dout0, brdo0, baddr0, bdin0;
    logic [1:0]   ack0, stall0;
    logic         err0, brdy0, busy0;
    logic [2:0]   brd0, bwr0;
    logic [0:0]   gid0;

    // Round-robin instance signals
    logic [2:0]   req1;
    logic [8:0]   rd1, wr1;
    logic [191:0] addr1, din1;
    logic [63:0]  dout1, brdo1, baddr1, bdin1;
    logic [2:0]   ack1, stall1;
    logic         err1, brdy1, busy1;
    logic [2:0]   brd1, bwr1;
    logic [1:0]   gid1;

    sys_bus_arbiter #(.N_MASTERS(2), .RR_MODE(0), .TIMEOUT_CYC(16)) u_fp (
        .clk(clk), .rst(rst), .m_req(req0), .m_rd_ctrl(rd0), .m_wr_ctrl(wr0),
        .m_addr(addr0), .m_din(din0), .m_dout(dout0), .m_ack(ack0), .m_err(err0),
        .m_stall(stall0), .bus_rd_ctrl(brd0), .bus_wr_ctrl(bwr0), .bus_addr(baddr0),
        .bus_din(bdin0), .bus_dout(brdo0), .bus_ready(brdy0), .busy(busy0), .grant_id(gid0)
    );

    sys_bus_arbiter #(.N_MASTERS(3), .RR_MODE(1), .TIMEOUT_CYC(16)) u_rr (
        .clk(clk), .rst(rst), .m_req(req1), .m_rd_ctrl(rd1), .m_wr_ctrl(wr1),
        .m_addr(addr1), .m_din(din1), .m_dout(dout1), .m_ack(ack1), .m_err(err1),
        .m_stall(stall1), .bus_rd_ctrl(brd1), .bus_wr_ctrl(bwr1), .bus_addr(baddr1),
        .bus_din(bdin1), .bus_dout(brdo1), .bus_ready(brdy1), .busy(busy1), .grant_id(gid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] a, input logic [63:0] d, input logic e);
        exp_t r;
        r.ack  = a;
        r.dout = d;
        r.err  = e;
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Completion monitors: every ack pulse must match the oldest expected entry.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (!rst && ack0 != 2'b00) begin
            if (q0.size() == 0) chk("fp_unexpected_ack", 64'(ack0), 64'd0);
            else begin
                e = q0.pop_front();
                chk("fp_ack", 64'(ack0), 64'(e.ack[1:0]));
                chk("fp_dout", dout0, e.dout);
                chk("fp_err", 64'(err0), 64'(e.err));
            end
            n_ack0 = n_ack0 + 1;
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (!rst && ack1 != 3'b000) begin
            if (q1.size() == 0) chk("rr_unexpected_ack", 64'(ack1), 64'd0);
            else begin
                e = q1.pop_front();
                chk("rr_ack", 64'(ack1), 64'(e.ack));
                chk("rr_dout", dout1, e.dout);
                chk("rr_err", 64'(err1), 64'(e.err));
            end
            tq.push_back(cyc);
            n_ack1 = n_ack1 + 1;
        end
    end

    initial begin
        int base;
        rst = 1'b1;
        req0 = '0; rd0 = '0; wr0 = '0; addr0 = '0; din0 = '0; brdo0 = '0; brdy0 = 1'b0;
        req1 = '0; rd1 = '0; wr1 = '0; addr1 = '0; din1 = '0; brdo1 = '0; brdy1 = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_ack", 64'(ack0), 64'd0);
        chk("rst_addr", baddr0, 64'd0);
        chk("rst_gid", 64'(gid0), 64'd0);
        chk("rst_dout", dout0, 64'd0);
        chk("rst_gid_rr", 64'(gid1), 64'd0);

        // Single read from master 1, slave always ready
        brdy0 = 1'b1; brdo0 = 64'hDEAD_BEEF;
        rd0[3 +: 3] = 3'b001; addr0[64 +: 64] = 64'h1000; req0 = 2'b10;
        q0.push_back(mk(3'b010, 64'hDEAD_BEEF, 1'b0));
        base = n_ack0;
        step();
        chk("t1_bus_addr", baddr0, 64'h1000);
        chk("t1_bus_rd", 64'(brd0), 64'd1);
        chk("t1_busy", 64'(busy0), 64'd1);
        chk("t1_gid", 64'(gid0), 64'd1);
        chk("t1_stall_busy", 64'(stall0), 64'b10);
        step();
        chk("t1_ack", 64'(ack0), 64'b10);
        chk("t1_stall_done", 64'(stall0), 64'b00);
        chk("t1_nack", 64'(n_ack0), 64'(base + 1));
        req0 = '0; rd0 = '0;
        step();
        chk("t1_ack_clear", 64'(ack0), 64'd0);
        chk("t1_bus_clear", baddr0, 64'd0);

        // Fixed-priority contention: master 0 must win every time
        rd0 = {3'b010, 3'b010}; addr0 = {64'h200, 64'h100}; brdo0 = 64'h1234; req0 = 2'b11;
        for (int k = 0; k < 4; k++) q0.push_back(mk(3'b001, 64'h1234, 1'b0));
        base = n_ack0;
        for (int c = 0; c < 20 && n_ack0 < base + 4; c++) begin
            step();
            chk("t2_stall1", 64'(stall0[1]), 64'd1);
        end
        chk("t2_nack", 64'(n_ack0), 64'(base + 4));
        req0 = '0; rd0 = '0;
        repeat (2) step();
        chk("t2_idle", 64'(busy0), 64'd0);

        // Write with slave wait states; request dropped while granted
        brdy0 = 1'b0; brdo0 = 64'h77;
        wr0[0 +: 3] = 3'b011; addr0[0 +: 64] = 64'h2008; din0[0 +: 64] = 64'h55; req0 = 2'b01;
        q0.push_back(mk(3'b001, 64'h77, 1'b0));
        base = n_ack0;
        for (int c = 1; c <= 4; c++) begin
            step();
            chk("t4_addr_hold", baddr0, 64'h2008);
            chk("t4_din_hold", bdin0, 64'h55);
            chk("t4_wr_hold", 64'(bwr0), 64'd3);
            chk("t4_no_ack", 64'(ack0), 64'd0);
            if (c == 4) begin
                brdy0 = 1'b1; req0 = '0; wr0 = '0;
            end
        end
        step();
        chk("t4_nack", 64'(n_ack0), 64'(base + 1));
        chk("t4_err", 64'(err0), 64'd0);
        chk("t4_bus_clear", baddr0, 64'd0);
        brdy0 = 1'b0;
        step();

        // Timeout after 16 BUSY cycles, then a normal transaction
        brdo0 = 64'hFFFF; rd0[3 +: 3] = 3'b001; addr0[64 +: 64] = 64'h3000; req0 = 2'b10;
        q0.push_back(mk(3'b010, 64'h0, 1'b1));
        base = n_ack0;
        for (int c = 1; c <= 16; c++) begin
            step();
            chk("t5_busy", 64'(busy0), 64'd1);
            chk("t5_no_ack", 64'(ack0), 64'd0);
        end
        step();
        chk("t5_ack", 64'(ack0), 64'b10);
        chk("t5_err", 64'(err0), 64'd1);
        req0 = '0;
        step();
        chk("t5_err_clear", 64'(err0), 64'd0);
        brdy0 = 1'b1; brdo0 = 64'hABC; addr0[64 +: 64] = 64'h3008; req0 = 2'b10;
        q0.push_back(mk(3'b010, 64'hABC, 1'b0));
        repeat (2) step();
        chk("t5_nack", 64'(n_ack0), 64'(base + 2));
        req0 = '0; rd0 = '0; brdy0 = 1'b0;
        step();

        // Round-robin rotation over three masters
        tq.delete();
        brdy1 = 1'b1; brdo1 = 64'h42; rd1 = {3'b001, 3'b001, 3'b001};
        addr1 = {64'h30, 64'h20, 64'h10}; req1 = 3'b111;
        q1.push_back(mk(3'b001, 64'h42, 1'b0));
        q1.push_back(mk(3'b010, 64'h42, 1'b0));
        q1.push_back(mk(3'b100, 64'h42, 1'b0));
        q1.push_back(mk(3'b001, 64'h42, 1'b0));
        base = n_ack1;
        step();
        chk("t3_stall", 64'(stall1), 64'b111);
        for (int c = 0; c < 20 && n_ack1 < base + 4; c++) step();
        chk("t3_nack", 64'(n_ack1), 64'(base + 4));
        chk("t3_gid_last", 64'(gid1), 64'd0);
        req1 = '0; rd1 = '0;
        if (tq.size() == 4) begin
            for (int k = 1; k < 4; k++) chk("t3_spacing", 64'(tq[k] - tq[k-1]), 64'd3);
        end else chk("t3_ack_count", 64'(tq.size()), 64'd4);
        step();

        // Reset in the second BUSY cycle of both instances
        brdy0 = 1'b0; rd0[3 +: 3] = 3'b001; addr0[64 +: 64] = 64'h4000; req0 = 2'b10;
        brdy1 = 1'b0; rd1[3 +: 3] = 3'b001; addr1[64 +: 64] = 64'h4000; req1 = 3'b010;
        base = n_ack0 + n_ack1;
        step();
        chk("t6_busy_fp", 64'(busy0), 64'd1);
        chk("t6_busy_rr", 64'(busy1), 64'd1);
        step();
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", 64'(busy0), 64'd0);
        chk("t6_rst_addr", baddr0, 64'd0);
        chk("t6_rst_rd", 64'(brd0), 64'd0);
        chk("t6_rst_gid", 64'(gid0), 64'd0);
        chk("t6_rst_busy_rr", 64'(busy1), 64'd0);
        chk("t6_rst_addr_rr", baddr1, 64'd0);
        chk("t6_rst_gid_rr", 64'(gid1), 64'd0);
        chk("t6_rst_bus_rr", {bdin1[60:0], bwr1}, 64'd0);
        req0 = '0; req1 = '0;
        step();
        rst = 1'b0;
        chk("t6_no_ack", 64'(n_ack0 + n_ack1), 64'(base));
        brdy0 = 1'b1; brdo0 = 64'h99; rd0 = {3'b001, 3'b001}; req0 = 2'b11;
        brdy1 = 1'b1; brdo1 = 64'h66; rd1 = {3'b001, 3'b001, 3'b001}; req1 = 3'b111;
        q0.push_back(mk(3'b001, 64'h99, 1'b0));
        q1.push_back(mk(3'b001, 64'h66, 1'b0));
        repeat (2) step();
        chk("t6_first_fp", 64'(gid0), 64'd0);
        chk("t6_first_rr", 64'(gid1), 64'd0);
        chk("t6_nack", 64'(n_ack0 + n_ack1), 64'(base + 2));
        req0 = '0; req1 = '0; rd0 = '0; rd1 = '0;
        repeat (2) step();

        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sys_bus_arbiter.md
Name: sys_bus_arbiter

Overview:
- Parametrised multi-master arbiter in front of the single sys_bus port of the pipelined CPU.
- Replaces the hard-wired instruction-fetch/data-memory address mux with a registered request/grant/acknowledge handshake.
- Supports N masters, fixed-priority or round-robin arbitration, multi-cycle slaves via bus_ready, and a per-transaction timeout with error reporting.
- Instance 0 is the MEM stage, instance 1 is IF; DMA or debug masters are added by raising N_MASTERS.

Parameters:
N_MASTERS, 2, number of requesting masters (>=2); index 0 is the highest fixed priority
ADDR_W, 64, address width
DATA_W, 64, data width
CTRL_W, 3, width of the rd/wr control codes; code 0 means no access
RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round robin
TIMEOUT_CYC, 16, number of BUSY cycles without bus_ready before abort; 0 disables the timeout
GID_W, $clog2(N_MASTERS), width of grant_id

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active high
m_req  in  N_MASTERS  per-master request; held high until the master sees m_ack
m_rd_ctrl  in  N_MASTERS*CTRL_W  flattened read control; master i occupies slice [i*CTRL_W +: CTRL_W]
m_wr_ctrl  in  N_MASTERS*CTRL_W  flattened write control
m_addr  in  N_MASTERS*ADDR_W  flattened address
m_din  in  N_MASTERS*DATA_W  flattened write data
m_dout  out  DATA_W  read data returned to the acknowledged master; valid while its m_ack is high
m_ack  out  N_MASTERS  one-hot, one-cycle completion pulse
m_err  out  1  high together with m_ack when the transaction timed out
m_stall  out  N_MASTERS  m_req & ~m_ack (combinational); pipeline stall for each master
bus_rd_ctrl  out  CTRL_W  registered read control to sys_bus
bus_wr_ctrl  out  CTRL_W  registered write control to sys_bus
bus_addr  out  ADDR_W  registered address to sys_bus
bus_din  out  DATA_W  registered write data to sys_bus
bus_dout  in  DATA_W  read data from sys_bus
bus_ready  in  1  slave has completed the access this cycle
busy  out  1  high in BUSY state
grant_id  out  GID_W  index of the current or most recent owner

Behaviour:
- Reset state:
  - state = IDLE.
  - All bus_* outputs, m_dout, m_ack, m_err, busy and grant_id are 0.
  - The round-robin pointer is N_MASTERS-1, so master 0 wins first.
  - Timeout counter is 0.
- Eligibility: master i is eligible when m_req[i] is high AND (its rd_ctrl != 0 OR its wr_ctrl != 0). An ineligible request is never granted and stays stalled.
- IDLE state:
  - If no master is eligible, remain in IDLE.
  - Otherwise select the winner g:
    - RR_MODE=0: lowest eligible index.
    - RR_MODE=1: first eligible index searching upward from pointer+1, wrapping modulo N_MASTERS.
  - At the clock edge: register g's rd_ctrl, wr_ctrl, addr and din onto bus_*; set grant_id = g; set pointer = g; clear the counter; go to BUSY.
- BUSY state:
  - bus_* outputs are held stable; busy = 1.
  - If bus_ready = 1: capture bus_dout into m_dout, set m_ack[g] = 1 and m_err = 0, drive bus_* to 0, go to DONE.
  - Else if TIMEOUT_CYC != 0 and counter == TIMEOUT_CYC-1: set m_dout = 0, m_ack[g] = 1, m_err = 1, drive bus_* to 0, go to DONE.
  - Else increment the counter.
- DONE state:
  - Lasts exactly one cycle; m_ack and m_err are visible only in this cycle.
  - No arbitration happens, so an acknowledged master can drop or refresh its request before it is sampled again.
  - Next state is IDLE. m_ack and m_err clear to 0.
- Latency:
  - Request sampled in cycle 0 puts the command on the bus in cycle 1.
  - With bus_ready high in cycle 1, m_ack is high in cycle 2.
  - Minimum occupancy is 3 cycles per transaction; each extra slave wait cycle adds 1.
- Request rules:
  - Changes to a master's request inputs during BUSY have no effect; the command is latched.
  - A master that drops m_req while granted still completes and receives m_ack.
- Ready outside BUSY: bus_ready in IDLE or DONE is ignored.
- Control pass-through: rd_ctrl and wr_ctrl both nonzero are forwarded unchanged; decoding is the slave's responsibility.
- Reset mid-transaction: asserting rst in BUSY or DONE immediately forces IDLE and zeroes all outputs. No m_ack is issued and the pointer returns to N_MASTERS-1.
- Arithmetic:
  - The counter is wide enough for TIMEOUT_CYC with no wrap.
  - The round-robin index wraps modulo N_MASTERS, so non-power-of-two N_MASTERS is supported.

Test Plan:
1. Single read, no wait: N=2, master 1 requests rd_ctrl=3'b001 at addr=0x1000; bus_ready tied to 1 and bus_dout=0xDEAD_BEEF.
   -> bus_addr = 0x1000 in cycle 1; m_ack = 2'b10 and m_dout = 0xDEAD_BEEF in cycle 2; m_stall[1] = 0 in cycle 2.
2. Fixed-priority contention: RR_MODE=0, both masters request continuously.
   -> master 0 is granted every transaction; m_stall[1] stays high throughout.
3. Round-robin rotation: RR_MODE=1, N=3, all three masters request continuously.
   -> grant_id sequence 0,1,2,0; each m_ack pulse lasts exactly 1 cycle, spaced 3 cycles apart.
4. Slave wait states: write wr_ctrl=3'b011, addr=0x2008, din=0x55; bus_ready asserted after 4 BUSY cycles.
   -> bus_* hold 0x2008/0x55 for 4 cycles; m_ack follows the ready cycle; m_err = 0.
5. Timeout: TIMEOUT_CYC=16, bus_ready held at 0.
   -> m_ack and m_err pulse together after 16 BUSY cycles with m_dout = 0; the next request is then serviced normally.
6. Reset during BUSY: assert rst in the 2nd BUSY cycle.
   -> all outputs 0 immediately, no m_ack; after release, master 0 is granted first.
